// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data memory.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Word-index width for a power-of-two depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous per-byte write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BYTE_LANES-1:0] i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Write only the byte lanes whose enable is set.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request in flight, fixed wait, held response.
// Optional build macro DMEM_BYTE_STROBE_EN adds req_be byte strobes for stores
// (store alignment check relaxed; loads still must be word aligned).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request (req_ready high one cycle after reset)
// ST_WAIT | counting down the access latency, access done at count 0
// ST_RESP | response held until rsp_valid & rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [BYTE_LANES-1:0] req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = idx_width(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_we;
  logic [WORD_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic [WORD_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                  w_accept;
  logic                  w_acc_now;
  logic                  w_acc_we;
  logic [WORD_W-1:0]     w_acc_addr;
  logic [WORD_W-1:0]     w_acc_wdata;
  logic [BYTE_LANES-1:0] w_acc_be;
  logic                  w_misalign;
  logic                  w_range;
  logic                  w_err;
  logic                  w_mem_we;
  logic [WORD_W-1:0]     w_rdata;

  assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;

  // With zero latency the access happens on the accepting edge straight from
  // the request inputs; otherwise it uses the captured copy at count zero.
  assign w_acc_now   = (LATENCY == 0) ? w_accept : ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_acc_we    = (LATENCY == 0) ? req_we    : r_we;
  assign w_acc_addr  = (LATENCY == 0) ? req_addr  : r_addr;
  assign w_acc_wdata = (LATENCY == 0) ? req_wdata : r_wdata;

`ifdef DMEM_BYTE_STROBE_EN
  logic [BYTE_LANES-1:0] r_be;
  assign w_acc_be   = (LATENCY == 0) ? req_be : r_be;
  assign w_misalign = (w_acc_addr[1:0] != 2'b00) && !w_acc_we;

  // Strobes travel with the rest of the captured request.
  always_ff @(posedge clk) begin
    if (w_accept) r_be <= req_be;
  end
`else
  assign w_acc_be   = '1;
  assign w_misalign = (w_acc_addr[1:0] != 2'b00);
`endif

  assign w_range  = |w_acc_addr[WORD_W-1:IDX_W+2];
  assign w_err    = w_misalign || w_range;
  assign w_mem_we = w_acc_now && w_acc_we && !w_err;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_be    (w_acc_be),
    .i_idx   (w_acc_addr[IDX_W+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  // Request sequencing, latency countdown and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            if (LATENCY == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_acc_now) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (!w_acc_we && !w_err) ? w_rdata : '0;
        r_rsp_err   <= w_err;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=0, instance 1 LATENCY=2.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv [2];
  logic        rr [2];
  logic        we [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];
  logic        sv [2];
  logic        sr [2];
  logic [31:0] rd [2];
  logic        er [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(be[0]),
`endif
    .rsp_valid(sv[0]), .rsp_ready(sr[0]), .rsp_rdata(rd[0]), .rsp_err(er[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(be[1]),
`endif
    .rsp_valid(sv[1]), .rsp_ready(sr[1]), .rsp_rdata(rd[1]), .rsp_err(er[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_ph  [2];   // 0 idle, 1 waiting, 2 responding
  bit          m_rdy [2];
  bit          m_val [2];
  logic [31:0] m_rd  [2];
  bit          m_er  [2];
  int          m_rem [2];
  bit          c_we  [2];
  logic [31:0] c_ad  [2];
  logic [31:0] c_wd  [2];
  logic [3:0]  c_be  [2];
  logic [31:0] m_mem [2][DEPTH];
  bit          armed = 1'b0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic m_access(input int k);
    bit e;
    int w;
    w = int'(c_ad[k] / 4);
    e = (c_ad[k] >= 32'(4 * DEPTH));
`ifdef DMEM_BYTE_STROBE_EN
    if (!c_we[k] && (c_ad[k] % 4 != 0)) e = 1'b1;
`else
    if (c_ad[k] % 4 != 0) e = 1'b1;
`endif
    m_er[k] = e;
    m_rd[k] = 32'd0;
    if (!e) begin
      if (c_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (c_be[k][b]) m_mem[k][w][8*b +: 8] = c_wd[k][8*b +: 8];
      end else begin
        m_rd[k] = m_mem[k][w];
      end
    end
    m_val[k] = 1'b1;
    m_ph[k]  = 2;
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) armed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ph[k] = 0; m_rdy[k] = 1'b0; m_val[k] = 1'b0; m_rd[k] = 32'd0; m_er[k] = 1'b0;
      end else begin
        case (m_ph[k])
          0: if (m_rdy[k] && rv[k]) begin
               c_we[k] = we[k]; c_ad[k] = ad[k]; c_wd[k] = wd[k]; c_be[k] = be[k];
               m_rdy[k] = 1'b0;
               m_rem[k] = lat_of(k);
               if (m_rem[k] == 0) m_access(k);
               else               m_ph[k] = 1;
             end else begin
               m_rdy[k] = 1'b1;
             end
          1: begin
               m_rem[k]--;
               if (m_rem[k] == 0) m_access(k);
             end
          default: if (sr[k]) begin
               m_ph[k] = 0; m_val[k] = 1'b0; m_rdy[k] = 1'b1;
             end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), 32'(rr[k]), 32'(m_rdy[k]));
        chk($sformatf("rsp_valid[%0d]", k), 32'(sv[k]), 32'(m_val[k]));
        if (m_val[k]) begin
          chk($sformatf("rsp_rdata[%0d]", k), rd[k], m_rd[k]);
          chk($sformatf("rsp_err[%0d]", k), 32'(er[k]), 32'(m_er[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] strb, input int hold, input logic [31:0] hold_exp,
                      output logic [31:0] o_rd, output logic o_er, output int lat);
    int n;
    @(negedge clk);
    rv[k] = 1'b1; we[k] = w; ad[k] = a; wd[k] = d; be[k] = strb;
    sr[k] = (hold == 0);
    n = 0;
    while (!rr[k] && n <= 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n <= 20), 32'd1);
    @(negedge clk);
    if (hold == 0) rv[k] = 1'b0;
    lat = 1;
    while (!sv[k] && lat < 30) begin @(negedge clk); lat++; end
    chk("rsp_timeout", 32'(lat < 30), 32'd1);
    o_rd = rd[k];
    o_er = er[k];
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", 32'(sv[k]), 32'd1);
      chk("bp_rdata", rd[k], hold_exp);
      chk("bp_ready", 32'(rr[k]), 32'd0);
      @(negedge clk);
    end
    sr[k] = 1'b1;
    @(negedge clk);
    rv[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    int          cnt;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; we[k] = 1'b0; ad[k] = '0; wd[k] = '0; be[k] = 4'hF; sr[k] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_valid", 32'(sv[1]), 32'd0);
    chk("reset_rdata", rd[1], 32'd0);
    chk("reset_err", 32'(er[1]), 32'd0);
    @(negedge clk);
    chk("ready_after_reset", 32'(rr[1]), 32'd1);

    // store/load, LATENCY=2
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, e, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_rdata", r, 32'd0);
    chk("st_err", 32'(e), 32'd0);
    xact(1, 1'b0, 32'h10, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_rdata", r, 32'hDEADBEEF);
    chk("ld_err", 32'(e), 32'd0);

    // backpressure: response held 5 cycles, competing request held high
    xact(1, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF, r, e, lat);
    chk("bp_rdata_first", r, 32'hDEADBEEF);

    // error cases
    xact(1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, r, e, lat);
    xact(1, 1'b0, 32'h12, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", r, 32'd0);
    xact(1, 1'b1, 32'h100, 32'h5A5A5A5A, 4'hF, 0, 0, r, e, lat);
    chk("oor_err", 32'(e), 32'd1);
    xact(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("word0_kept", r, 32'hA5A5A5A5);
    xact(1, 1'b1, 32'hFC, 32'h0BADF00D, 4'hF, 0, 0, r, e, lat);
    chk("top_st_err", 32'(e), 32'd0);
    xact(1, 1'b0, 32'hFC, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("top_ld", r, 32'h0BADF00D);
    xact(1, 1'b0, 32'h80000000, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("hi_err", 32'(e), 32'd1);

    // LATENCY=0
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, r, e, lat);
    chk("l0_st_lat", 32'(lat), 32'd1);
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("l0_ld_lat", 32'(lat), 32'd1);
    chk("l0_ld_rdata", r, 32'hCAFEF00D);
    rv[0] = 1'b1; we[0] = 1'b0; ad[0] = 32'h20; sr[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rr[0]) cnt++;
      @(negedge clk);
    end
    rv[0] = 1'b0;
    chk("l0_b2b_accepts", 32'(cnt), 32'd3);

    // reset while waiting discards a pending store
    xact(1, 1'b1, 32'h4, 32'h11111111, 4'hF, 0, 0, r, e, lat);
    @(negedge clk);
    rv[1] = 1'b1; we[1] = 1'b1; ad[1] = 32'h4; wd[1] = 32'h12345678; be[1] = 4'hF;
    cnt = 0;
    while (!rr[1] && cnt <= 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    rv[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait_valid", 32'(sv[1]), 32'd0);
    chk("rst_wait_rdata", rd[1], 32'd0);
    chk("rst_wait_ready", 32'(rr[1]), 32'd0);
    @(negedge clk);
    chk("rst_wait_ready_back", 32'(rr[1]), 32'd1);
    xact(1, 1'b0, 32'h4, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("rst_wait_kept", r, 32'h11111111);

`ifdef DMEM_BYTE_STROBE_EN
    xact(1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, r, e, lat);
    xact(1, 1'b1, 32'h8, 32'h000000AB, 4'b0001, 0, 0, r, e, lat);
    xact(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("be_lane0", r, 32'hFFFFFFAB);
    xact(1, 1'b1, 32'hA, 32'h00CD0000, 4'b0100, 0, 0, r, e, lat);
    chk("be_unaligned_err", 32'(e), 32'd0);
    xact(1, 1'b1, 32'h8, 32'h0, 4'b0000, 0, 0, r, e, lat);
    chk("be_zero_err", 32'(e), 32'd0);
    xact(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 0, r, e, lat);
    chk("be_lane2", r, 32'hFFCDFFAB);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
